// File: rtl/sd_dma_sequencer.sv
// SD host command/data sequencer: CMD issue, per-block DATA strobes, done/err.
// Optional automatic stop command is enabled by defining SEQ_AUTO_STOP_EN.
module sd_dma_sequencer #(
  parameter int CMD_TIMEOUT = 1023,
  parameter int BLK_W       = 4
) (
  input  logic             clk_host,
  input  logic             reset_host,
  input  logic             start,
  input  logic             data_present,
  input  logic             multiple_data,
  input  logic [BLK_W-1:0] block_count,
  input  logic             abort,
  output logic             new_command,
  output logic             auto_stop,
  input  logic             cmd_complete,
  input  logic             cmd_index_error,
  output logic             new_dat,
  input  logic             transfer_complete,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [BLK_W-1:0] blocks_done
);

  localparam int TW = (CMD_TIMEOUT < 1) ? 1 : $clog2(CMD_TIMEOUT + 1);
  localparam logic [TW-1:0]    T_MAX = TW'(CMD_TIMEOUT);
  localparam logic [BLK_W-1:0] B_MAX = '1;
  localparam logic [BLK_W-1:0] B_ONE = BLK_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_CMD,
    WAIT_CMD,
    ISSUE_DAT,
    WAIT_DAT,
    ISSUE_STOP,
    WAIT_STOP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             dp_q, dp_d;
  logic             md_q, md_d;
  logic [BLK_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_inc;

  // saturating block counter, never wraps
  assign blk_inc = (blk_q == B_MAX) ? B_MAX : blk_q + B_ONE;

  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) begin
      state_q <= IDLE;
      err_q   <= '0;
      blk_q   <= '0;
      timer_q <= '0;
      dp_q    <= 1'b0;
      md_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      blk_q   <= blk_d;
      timer_q <= timer_d;
      dp_q    <= dp_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    blk_d   = blk_q;
    timer_d = timer_q;
    dp_d    = dp_q;
    md_d    = md_q;
    cnt_d   = cnt_q;
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_d = DONE;
      err_d   = 2'b11;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dp_d    = data_present;
            md_d    = multiple_data;
            cnt_d   = (block_count == '0) ? B_ONE : block_count;
            err_d   = 2'b00;
            blk_d   = '0;
            timer_d = '0;
            state_d = ISSUE_CMD;
          end
        end
        ISSUE_CMD: begin
          timer_d = '0;
          state_d = WAIT_CMD;
        end
        WAIT_CMD: begin
          if (cmd_index_error) begin
            state_d = DONE;
            err_d   = 2'b01;
          end else if (cmd_complete) begin
            state_d = dp_q ? ISSUE_DAT : DONE;
          end else if (timer_q == T_MAX) begin
            state_d = DONE;
            err_d   = 2'b10;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ISSUE_DAT: begin
          state_d = WAIT_DAT;
        end
        WAIT_DAT: begin
          if (transfer_complete) begin
            blk_d = blk_inc;
            if (md_q && blk_inc < cnt_q) begin
              state_d = ISSUE_DAT;
            end else begin
`ifdef SEQ_AUTO_STOP_EN
              state_d = md_q ? ISSUE_STOP : DONE;
`else
              state_d = DONE;
`endif
            end
          end
        end
`ifdef SEQ_AUTO_STOP_EN
        ISSUE_STOP: begin
          timer_d = '0;
          state_d = WAIT_STOP;
        end
        WAIT_STOP: begin
          if (cmd_index_error) begin
            state_d = DONE;
            err_d   = 2'b01;
          end else if (cmd_complete) begin
            state_d = DONE;
          end else if (timer_q == T_MAX) begin
            state_d = DONE;
            err_d   = 2'b10;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`endif
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign new_command = (state_q == ISSUE_CMD) ||
                       (state_q == ISSUE_STOP);
`ifdef SEQ_AUTO_STOP_EN
  assign auto_stop   = (state_q == ISSUE_STOP);
`else
  assign auto_stop   = 1'b0;
`endif
  assign new_dat     = (state_q == ISSUE_DAT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_code    = err_q;
  assign blocks_done = blk_q;

endmodule

// File: tb/tb_sd_dma_sequencer.sv
// Bench for sd_dma_sequencer: timeline model built from transaction plans,
// per-cycle compare of every output, plus literal pins on the model.
module tb_sd_dma_sequencer;

  localparam int T  = 8;
  localparam int BW = 4;
  localparam int N  = 512;
  localparam int BM = (1 << BW) - 1;

  logic          clk_host = 1'b0;
  logic          reset_host;
  logic          start, data_present, multiple_data;
  logic [BW-1:0] block_count;
  logic          abort, cmd_complete, cmd_index_error;
  logic          transfer_complete;
  logic          new_command, auto_stop, new_dat;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [BW-1:0] blocks_done;

  always #5 clk_host = ~clk_host;

  sd_dma_sequencer #(.CMD_TIMEOUT(T), .BLK_W(BW)) dut (
    .clk_host(clk_host),
    .reset_host(reset_host),
    .start(start),
    .data_present(data_present),
    .multiple_data(multiple_data),
    .block_count(block_count),
    .abort(abort),
    .new_command(new_command),
    .auto_stop(auto_stop),
    .cmd_complete(cmd_complete),
    .cmd_index_error(cmd_index_error),
    .new_dat(new_dat),
    .transfer_complete(transfer_complete),
    .busy(busy),
    .done(done),
    .err_code(err_code),
    .blocks_done(blocks_done)
  );

  bit            i_st[N], i_dp[N], i_md[N], i_ab[N];
  bit            i_cc[N], i_ie[N], i_tc[N];
  logic [BW-1:0] i_bc[N];
  bit            e_nc[N], e_as[N], e_nd[N], e_bz[N], e_dn[N];
  logic [1:0]    e_er[N];
  logic [BW-1:0] e_bk[N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit live  = 1'b0;
  int rst_at = -1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic set_er(input int c, input logic [1:0] v);
    for (int i = c; i < N; i++) e_er[i] = v;
  endtask

  task automatic set_bk(input int c, input logic [BW-1:0] v);
    for (int i = c; i < N; i++) e_bk[i] = v;
  endtask

  function automatic int cnt_nd(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (e_nd[i]) n++;
    return n;
  endfunction

  // kind: 0 normal, 1 index error, 2 cmd timeout, 3 abort after ab_after blocks
  task automatic plan(input int s, input int dp, input int md,
                      input int bc, input int dc, input int dd,
                      input int kind, input int ab_after,
                      output int fin);
    int c, r, p, tc, d, nb, blk, a;
    nb = (bc == 0) ? 1 : bc;
    if (md == 0) nb = 1;
    i_st[s] = 1'b1;
    i_dp[s] = (dp != 0);
    i_md[s] = (md != 0);
    i_bc[s] = BW'(bc);
    set_er(s + 1, 2'b00);
    set_bk(s + 1, '0);
    c = s + 1;
    e_nc[c] = 1'b1;
    blk = 0;
    d = 0;
    if (kind == 2) begin
      d = c + T + 2;
      set_er(d, 2'b10);
    end else begin
      r = c + dc;
      i_cc[r] = 1'b1;
      if (kind == 1) begin
        i_ie[r] = 1'b1;
        d = r + 1;
        set_er(d, 2'b01);
      end else if (dp == 0) begin
        d = r + 1;
      end else begin
        p = r + 1;
        while (d == 0) begin
          e_nd[p] = 1'b1;
          if (kind == 3 && blk == ab_after) begin
            a = p + dd;
            i_ab[a] = 1'b1;
            i_tc[a] = 1'b1;
            d = a + 1;
            set_er(d, 2'b11);
          end else begin
            tc = p + dd;
            i_tc[tc] = 1'b1;
            if (blk < BM) blk++;
            set_bk(tc + 1, BW'(blk));
            if (md != 0 && blk < nb) begin
              p = tc + 1;
            end else begin
`ifdef SEQ_AUTO_STOP_EN
              if (md != 0) begin
                e_nc[tc + 1] = 1'b1;
                e_as[tc + 1] = 1'b1;
                i_cc[tc + 1 + dc] = 1'b1;
                d = tc + 2 + dc;
              end else begin
                d = tc + 1;
              end
`else
              d = tc + 1;
`endif
            end
          end
        end
      end
    end
    e_dn[d] = 1'b1;
    for (int i = s + 1; i <= d; i++) e_bz[i] = 1'b1;
    fin = d;
  endtask

  task automatic trunc(input int r, input int f);
    for (int i = r; i <= f; i++) begin
      i_st[i] = 0; i_ab[i] = 0; i_cc[i] = 0;
      i_ie[i] = 0; i_tc[i] = 0;
      e_nc[i] = 0; e_as[i] = 0; e_nd[i] = 0;
      e_bz[i] = 0; e_dn[i] = 0;
    end
    set_er(r, 2'b00);
    set_bk(r, '0);
  endtask

  always @(negedge clk_host) begin
    if (live) begin
      chk("new_command", new_command, e_nc[cyc]);
      chk("auto_stop", auto_stop, e_as[cyc]);
      chk("new_dat", new_dat, e_nd[cyc]);
      chk("busy", busy, e_bz[cyc]);
      chk("done", done, e_dn[cyc]);
      chk("err_code", err_code, e_er[cyc]);
      chk("blocks_done", blocks_done, e_bk[cyc]);
    end
  end

  initial begin
    int s, f, last;
    for (int i = 0; i < N; i++) begin
      i_bc[i] = '0;
      e_er[i] = 2'b00;
      e_bk[i] = '0;
    end

    // command only, stray start/transfer_complete ignored
    s = 2;
    plan(s, 0, 0, 0, 5, 1, 0, 0, f);
    chk("pin_cmd_only_done", f, s + 7);
    i_st[s + 3] = 1'b1;
    i_tc[s + 3] = 1'b1;
    i_st[f] = 1'b1;

    // three-block transfer, stray cmd_complete in WAIT_DAT
    s = f + 2;
    plan(s, 1, 1, 3, 2, 3, 0, 0, f);
    i_cc[s + 5] = 1'b1;
    chk("pin_multi_nd", cnt_nd(s, f), 3);
    chk("pin_multi_blk", e_bk[f], 3);

    // command timeout
    s = f + 2;
    plan(s, 0, 0, 0, 0, 0, 2, 0, f);
    chk("pin_timeout_lat", f - (s + 1), 10);

    // index error together with cmd_complete
    s = f + 2;
    plan(s, 1, 1, 2, 3, 2, 1, 0, f);
    chk("pin_idx_err", e_er[f], 2'b01);
    chk("pin_idx_nd", cnt_nd(s, f), 0);

    // abort in WAIT_DAT after one of four blocks
    s = f + 2;
    plan(s, 1, 1, 4, 1, 4, 3, 1, f);
    chk("pin_abort_blk", e_bk[f], 1);
    chk("pin_abort_err", e_er[f], 2'b11);

    // abort while idle ignored, single block ignores block_count
    s = f + 3;
    i_ab[s - 1] = 1'b1;
    plan(s, 1, 0, 5, 3, 2, 0, 0, f);
    chk("pin_single_nd", cnt_nd(s, f), 1);
    chk("pin_err_held", e_er[s], 2'b11);

    // block_count 0 treated as one block
    s = f + 2;
    plan(s, 1, 1, 0, 2, 2, 0, 0, f);
    chk("pin_bc0_nd", cnt_nd(s, f), 1);

    // cmd_complete on the last cycle before timeout
    s = f + 2;
    plan(s, 0, 0, 0, T + 1, 1, 0, 0, f);
    chk("pin_edge_done", f, s + T + 3);

    // reset during WAIT_DAT after one block
    s = f + 2;
    plan(s, 1, 1, 4, 2, 3, 0, 0, f);
    rst_at = s + 10;
    chk("pin_rst_blk", e_bk[rst_at - 1], 1);
    trunc(rst_at, f);

    s = rst_at + 3;
    plan(s, 1, 1, 2, 1, 1, 0, 0, f);
    chk("pin_post_rst_blk", e_bk[f], 2);
    last = f + 3;

    reset_host = 1'b0;
    start = 0; data_present = 0; multiple_data = 0;
    block_count = '0; abort = 0; cmd_complete = 0;
    cmd_index_error = 0; transfer_complete = 0;

    for (int c = 0; c <= last; c++) begin
      @(posedge clk_host);
      #1;
      cyc = c;
      live = 1'b1;
      start = i_st[c];
      data_present = i_dp[c];
      multiple_data = i_md[c];
      block_count = i_bc[c];
      abort = i_ab[c];
      cmd_complete = i_cc[c];
      cmd_index_error = i_ie[c];
      transfer_complete = i_tc[c];
      if (c == 1 || c == rst_at + 1) reset_host = 1'b1;
      if (c == rst_at) begin
        #1 reset_host = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_new_dat", new_dat, 1'b0);
        chk("rst_new_command", new_command, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_blocks", blocks_done, '0);
        chk("rst_err", err_code, 2'b00);
      end
    end
    @(posedge clk_host);
    live = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
